// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered occupancy count, almost-full/empty thresholds and sticky ovf/udf.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through read data; the default build registers read data.
module sync_fifo #(
    parameter int FIFO_WIDTH = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int AF_LEVEL   = 6,
    parameter int AE_LEVEL   = 2
) (
    input  logic                          fifo_clk,
    input  logic                          fifo_rst,
    input  logic                          fifo_clr,
    input  logic                          fifo_wen,
    input  logic [FIFO_WIDTH-1:0]         fifo_wdata,
    output logic                          fifo_full,
    output logic                          fifo_afull,
    input  logic                          fifo_ren,
    output logic [FIFO_WIDTH-1:0]         fifo_rdata,
    output logic                          fifo_empty,
    output logic                          fifo_aempty,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          fifo_ovf,
    output logic                          fifo_udf
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count_nxt;
    logic                  wr_acc;
    logic                  rd_acc;

    // Acceptance is decided from the registered flags, so full+wen+ren drops the write
    // and empty+wen+ren ignores the read.
    always_comb begin
        wr_acc    = fifo_wen && !fifo_full;
        rd_acc    = fifo_ren && !fifo_empty;
        count_nxt = fifo_count;
        if (wr_acc && !rd_acc)
            count_nxt = fifo_count + 1'b1;
        else if (rd_acc && !wr_acc)
            count_nxt = fifo_count - 1'b1;
    end

    always_ff @(posedge fifo_clk or posedge fifo_rst) begin
        if (fifo_rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            fifo_full   <= 1'b0;
            fifo_afull  <= 1'b0;
            fifo_empty  <= 1'b1;
            fifo_aempty <= 1'b1;
            fifo_ovf    <= 1'b0;
            fifo_udf    <= 1'b0;
        end else if (fifo_clr) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            fifo_full   <= 1'b0;
            fifo_afull  <= 1'b0;
            fifo_empty  <= 1'b1;
            fifo_aempty <= 1'b1;
            fifo_ovf    <= 1'b0;
            fifo_udf    <= 1'b0;
        end else begin
            if (wr_acc)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc)
                rd_ptr <= rd_ptr + 1'b1;
            fifo_count  <= count_nxt;
            fifo_full   <= (count_nxt == DEPTH_C);
            fifo_afull  <= (count_nxt >= AF_C);
            fifo_empty  <= (count_nxt == '0);
            fifo_aempty <= (count_nxt <= AE_C);
            if (fifo_wen && fifo_full)
                fifo_ovf <= 1'b1;
            if (fifo_ren && fifo_empty)
                fifo_udf <= 1'b1;
        end
    end

    always_ff @(posedge fifo_clk) begin
        if (wr_acc && !fifo_clr && !fifo_rst)
            mem[wr_ptr] <= fifo_wdata;
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign fifo_rdata = mem[rd_ptr];
`else
    always_ff @(posedge fifo_clk or posedge fifo_rst) begin
        if (fifo_rst)
            fifo_rdata <= '0;
        else if (rd_acc && !fifo_clr)
            fifo_rdata <= mem[rd_ptr];
    end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: scoreboard bench for sync_fifo (8x8, AF=6, AE=2); honours SYNC_FIFO_FWFT_EN.
module tb_sync_fifo;
    localparam int W  = 8;
    localparam int D  = 8;
    localparam int AF = 6;
    localparam int AE = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         clr;
    logic         wen;
    logic         ren;
    logic [W-1:0] wdata;
    logic         full;
    logic         afull;
    logic [W-1:0] rdata;
    logic         empty;
    logic         aempty;
    logic [3:0]   count;
    logic         ovf;
    logic         udf;

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] q[$];
    bit           movf = 1'b0;
    bit           mudf = 1'b0;
    logic [W-1:0] mrd  = '0;

    sync_fifo #(
        .FIFO_WIDTH (W),
        .FIFO_DEPTH (D),
        .AF_LEVEL   (AF),
        .AE_LEVEL   (AE)
    ) dut (
        .fifo_clk    (clk),
        .fifo_rst    (rst),
        .fifo_clr    (clr),
        .fifo_wen    (wen),
        .fifo_wdata  (wdata),
        .fifo_full   (full),
        .fifo_afull  (afull),
        .fifo_ren    (ren),
        .fifo_rdata  (rdata),
        .fifo_empty  (empty),
        .fifo_aempty (aempty),
        .fifo_count  (count),
        .fifo_ovf    (ovf),
        .fifo_udf    (udf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag);
        int n = q.size();
        check({tag, ".count"},  32'(count),  32'(n));
        check({tag, ".full"},   32'(full),   32'(n == D));
        check({tag, ".afull"},  32'(afull),  32'(n >= AF));
        check({tag, ".empty"},  32'(empty),  32'(n == 0));
        check({tag, ".aempty"}, 32'(aempty), 32'(n <= AE));
        check({tag, ".ovf"},    32'(ovf),    32'(movf));
        check({tag, ".udf"},    32'(udf),    32'(mudf));
`ifdef SYNC_FIFO_FWFT_EN
        if (n > 0)
            check({tag, ".head"}, 32'(rdata), 32'(q[0]));
`else
        check({tag, ".rdata"}, 32'(rdata), 32'(mrd));
`endif
    endtask

    // One clock: drive at posedge+1, update the scoreboard with the edge, check at next posedge+1.
    task automatic cycle(input string tag, input bit w, input logic [W-1:0] d, input bit r, input bit c);
        bit wa;
        bit ra;
        wen   = w;
        wdata = d;
        ren   = r;
        clr   = c;
        wa = w && (q.size() < D);
        ra = r && (q.size() > 0);
        @(posedge clk);
        if (c) begin
            q.delete();
            movf = 1'b0;
            mudf = 1'b0;
        end else begin
            if (w && !wa) movf = 1'b1;
            if (r && !ra) mudf = 1'b1;
            if (ra) mrd = q.pop_front();
            if (wa) q.push_back(d);
        end
        #1;
        wen = 1'b0;
        ren = 1'b0;
        clr = 1'b0;
        check_state(tag);
    endtask

    initial begin
        rst   = 1'b1;
        clr   = 1'b0;
        wen   = 1'b0;
        ren   = 1'b0;
        wdata = '0;
        #1;
        check_state("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 6; i++) cycle("pre_rst_wr", 1'b1, W'(8'h31 + i), 1'b0, 1'b0);
        cycle("pre_rst_rd", 1'b0, '0, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        q.delete();
        movf = 1'b0;
        mudf = 1'b0;
        mrd  = '0;
        check_state("async_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 8; i++) cycle("fill", 1'b1, W'(i), 1'b0, 1'b0);
        cycle("fill_ovf", 1'b1, 8'hFF, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cycle("drain", 1'b0, '0, 1'b1, 1'b0);
        cycle("drain_udf", 1'b0, '0, 1'b1, 1'b0);
        cycle("clr1", 1'b0, '0, 1'b0, 1'b1);

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 5; i++) cycle("wrap_wr", 1'b1, W'(8'h10 + r * 5 + i), 1'b0, 1'b0);
            for (int i = 0; i < 5; i++) cycle("wrap_rd", 1'b0, '0, 1'b1, 1'b0);
        end

        for (int i = 0; i < 8; i++) cycle("sfull_fill", 1'b1, W'(8'h40 + i), 1'b0, 1'b0);
        cycle("sim_full", 1'b1, 8'hEE, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) cycle("sfull_drain", 1'b0, '0, 1'b1, 1'b0);
        cycle("clr2", 1'b0, '0, 1'b0, 1'b1);

        cycle("sim_empty", 1'b1, 8'hA5, 1'b1, 1'b0);
        cycle("sempty_rd", 1'b0, '0, 1'b1, 1'b0);
        cycle("clr3", 1'b0, '0, 1'b0, 1'b1);

        for (int i = 0; i < 4; i++) cycle("flush_wr", 1'b1, W'(8'h60 + i), 1'b0, 1'b0);
        cycle("flush", 1'b1, 8'h77, 1'b0, 1'b1);
        cycle("post_flush_wr", 1'b1, 8'h55, 1'b0, 1'b0);
        cycle("post_flush_rd", 1'b0, '0, 1'b1, 1'b0);

        for (int i = 0; i < 300; i++)
            cycle("random", 1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 31) == 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
